// File: rtl/key_sync_context_bank.sv
// Multi-channel key/sync context store: loads 2*BLOCK_SIZE-byte key+sync words,
// serves one-cycle block reads and advances each channel's sync as a wide counter.
module key_sync_context_bank #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 16,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int BLOCK_SIZE = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [16*BLOCK_SIZE-1:0]  key_and_sync_in_data,
  input  logic                      key_and_sync_in_valid,
  output logic                      key_and_sync_in_rdy,
  input  logic                      load_en,
  input  logic [CH_W-1:0]           load_ch,
  input  logic                      blk_req,
  input  logic [CH_W-1:0]           blk_ch,
  input  logic                      blk_advance,
  input  logic [NUM_CH-1:0]         irq_clr,
  output logic [8*BLOCK_SIZE-1:0]   key,
  output logic [8*BLOCK_SIZE-1:0]   sync,
  output logic                      out_vld,
  output logic                      out_err,
  output logic [NUM_CH-1:0]         ctx_vld,
  output logic [NUM_CH-1:0]         irq_status,
  output logic                      sync_overlapse_irq
);

  localparam int BLK_W = 8 * BLOCK_SIZE;

  logic [BLK_W-1:0]  r_key   [NUM_CH];
  logic [BLK_W-1:0]  r_sync  [NUM_CH];
  logic [CNT_W-1:0]  r_cnt   [NUM_CH];
  logic [NUM_CH-1:0] r_ctx_vld;
  logic [NUM_CH-1:0] r_irq;

  logic              r_vld_p1;
  logic              r_err_p1;
  logic [BLK_W-1:0]  r_key_p1;
  logic [BLK_W-1:0]  r_sync_p1;

  logic              w_act;
  logic              w_rd_hit;
  logic [BLK_W-1:0]  w_rd_key;
  logic [BLK_W-1:0]  w_rd_sync;
  logic [NUM_CH-1:0] w_ld;
  logic [NUM_CH-1:0] w_adv;
  logic [NUM_CH-1:0] w_ovf;

  function automatic logic [BLK_W-1:0] sync_inc(input logic [BLK_W-1:0] s);
    return s + BLK_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return c + CNT_W'(1);
  endfunction

  assign key_and_sync_in_rdy = load_en;
  assign w_act               = key_and_sync_in_valid & load_en;

  // Out-of-range channel indices match no slot, so they fall out as discards/errors.
  always_comb begin
    w_ld      = '0;
    w_adv     = '0;
    w_ovf     = '0;
    w_rd_hit  = 1'b0;
    w_rd_key  = '0;
    w_rd_sync = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_ld[i]  = w_act && (load_ch == CH_W'(i));
      w_adv[i] = blk_req && blk_advance && (blk_ch == CH_W'(i)) && r_ctx_vld[i];
      w_ovf[i] = w_adv[i] && !w_ld[i] && (r_cnt[i] == '1);
      if (blk_req && (blk_ch == CH_W'(i)) && r_ctx_vld[i]) begin
        w_rd_hit  = 1'b1;
        w_rd_key  = r_key[i];
        w_rd_sync = r_sync[i];
      end
    end
  end

  // Stage p0 -> p1: context update and registered read response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_key[i]  <= '0;
        r_sync[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_ctx_vld <= '0;
      r_irq     <= '0;
      r_vld_p1  <= 1'b0;
      r_err_p1  <= 1'b0;
      r_key_p1  <= '0;
      r_sync_p1 <= '0;
    end else begin
      r_vld_p1  <= blk_req;
      r_err_p1  <= blk_req & ~w_rd_hit;
      r_key_p1  <= w_rd_key;
      r_sync_p1 <= w_rd_sync;
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_ld[i]) begin
          r_key[i]     <= key_and_sync_in_data[BLK_W-1:0];
          r_sync[i]    <= key_and_sync_in_data[2*BLK_W-1:BLK_W];
          r_cnt[i]     <= '0;
          r_ctx_vld[i] <= 1'b1;
        end else if (w_adv[i]) begin
          r_sync[i] <= sync_inc(r_sync[i]);
          r_cnt[i]  <= cnt_inc(r_cnt[i]);
        end
        r_irq[i] <= (r_irq[i] & ~irq_clr[i]) | w_ovf[i];
      end
    end
  end

  assign key                = r_key_p1;
  assign sync               = r_sync_p1;
  assign out_vld            = r_vld_p1;
  assign out_err            = r_err_p1;
  assign ctx_vld            = r_ctx_vld;
  assign irq_status         = r_irq;
  assign sync_overlapse_irq = |r_irq;

endmodule

// File: tb/tb_key_sync_context_bank.sv
// Scoreboard bench for key_sync_context_bank: directed loads/reads with expected
// responses queued at issue time and checked by an independent monitor.
module tb_key_sync_context_bank;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 2;
  localparam int CH_W   = 3;
  localparam int BS     = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [16*BS-1:0]   din;
  logic               din_vld;
  logic               din_rdy;
  logic               load_en;
  logic [CH_W-1:0]    load_ch;
  logic               blk_req;
  logic [CH_W-1:0]    blk_ch;
  logic               blk_advance;
  logic [NUM_CH-1:0]  irq_clr;
  logic [8*BS-1:0]    key;
  logic [8*BS-1:0]    sync;
  logic               out_vld;
  logic               out_err;
  logic [NUM_CH-1:0]  ctx_vld;
  logic [NUM_CH-1:0]  irq_status;
  logic               soi;

  key_sync_context_bank #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W), .BLOCK_SIZE(BS)
  ) dut (
    .clk(clk), .rst(rst),
    .key_and_sync_in_data(din), .key_and_sync_in_valid(din_vld),
    .key_and_sync_in_rdy(din_rdy),
    .load_en(load_en), .load_ch(load_ch),
    .blk_req(blk_req), .blk_ch(blk_ch), .blk_advance(blk_advance),
    .irq_clr(irq_clr),
    .key(key), .sync(sync), .out_vld(out_vld), .out_err(out_err),
    .ctx_vld(ctx_vld), .irq_status(irq_status), .sync_overlapse_irq(soi)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int           due;
    logic         err;
    logic [127:0] k;
    logic [127:0] s;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [127:0] ONES = '1;

  always @(posedge clk) cyc++;

  function automatic logic [127:0] mk(input logic [7:0] b);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = b + 8'(i);
    return r;
  endfunction

  // Monitor: pops one expectation per presented response
  always @(negedge clk) begin
    if (out_vld) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_rsp cyc=%0d err=%b key=%h sync=%h", cyc, out_err, key, sync);
      end else begin
        e = q.pop_front();
        if (cyc != e.due || out_err !== e.err || key !== e.k || sync !== e.s) begin
          n_bad++;
          $display("FAIL rsp cyc=%0d want_cyc=%0d err=%b want=%b key=%h want=%h sync=%h want=%h",
                   cyc, e.due, out_err, e.err, key, e.k, sync, e.s);
        end
      end
    end else begin
      n_cmp++;
      if (out_err !== 1'b0 || key !== '0 || sync !== '0) begin
        n_bad++;
        $display("FAIL idle_zero cyc=%0d err=%b key=%h sync=%h want all 0", cyc, out_err, key, sync);
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    din_vld     = 1'b0;
    load_en     = 1'b0;
    blk_req     = 1'b0;
    blk_advance = 1'b0;
    irq_clr     = '0;
  endtask

  task automatic issue_ld(input int ch, input logic [127:0] k, input logic [127:0] s);
    din_vld = 1'b1;
    load_en = 1'b1;
    load_ch = CH_W'(ch);
    din     = {s, k};
  endtask

  task automatic issue_rd(input int ch, input logic adv, input logic push,
                          input logic err, input logic [127:0] k, input logic [127:0] s);
    exp_t x;
    blk_req     = 1'b1;
    blk_ch      = CH_W'(ch);
    blk_advance = adv;
    if (push) begin
      x = '{due: cyc + 1, err: err, k: k, s: s};
      q.push_back(x);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; din = '0; din_vld = 1'b0; load_en = 1'b0; load_ch = '0;
    blk_req = 1'b0; blk_ch = '0; blk_advance = 1'b0; irq_clr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_vld", out_vld, 0);
    chk("rst_ctx_vld", ctx_vld, 0);
    chk("rst_irq", irq_status, 0);
    chk("rst_soi", soi, 0);
    load_en = 1'b1; #1;
    chk("rdy_follows_en1", din_rdy, 1);
    load_en = 1'b0; #1;
    chk("rdy_follows_en0", din_rdy, 0);
    rst = 1'b1;
    tick();

    // Basic load and read of ch2
    issue_ld(2, mk(8'h00), mk(8'h10)); tick();
    chk("ctx_after_ld2", ctx_vld, 4'b0100);
    issue_rd(2, 1'b0, 1'b1, 1'b0, mk(8'h00), mk(8'h10)); tick();

    // Unloaded and out-of-range reads, discarded loads
    issue_rd(1, 1'b0, 1'b1, 1'b1, '0, '0); tick();
    issue_rd(4, 1'b1, 1'b1, 1'b1, '0, '0); tick();
    issue_ld(4, mk(8'hEE), mk(8'hEF)); tick();
    din_vld = 1'b1; load_en = 1'b0; load_ch = '0; din = {mk(8'h33), mk(8'h44)}; tick();
    chk("ctx_after_discards", ctx_vld, 4'b0100);

    // Full-width sync wrap on ch1
    issue_ld(1, mk(8'h20), ONES); tick();
    issue_rd(1, 1'b1, 1'b1, 1'b0, mk(8'h20), ONES); tick();
    issue_rd(1, 1'b0, 1'b1, 1'b0, mk(8'h20), '0); tick();
    chk("irq_after_sync_wrap", irq_status, 0);
    chk("ctx_ch1_ch2", ctx_vld, 4'b0110);

    // Counter overflow on ch0 with CNT_W=2
    issue_ld(0, mk(8'h40), mk(8'h50)); tick();
    for (int k = 0; k < 3; k++) begin
      issue_rd(0, 1'b1, 1'b1, 1'b0, mk(8'h40), mk(8'h50) + 128'(k)); tick();
    end
    chk("irq_before_4th", irq_status, 0);
    issue_rd(0, 1'b1, 1'b1, 1'b0, mk(8'h40), mk(8'h50) + 128'd3); tick();
    chk("irq_after_4th", irq_status, 4'b0001);
    chk("soi_after_4th", soi, 1);
    irq_clr = 4'b0001; tick();
    chk("irq_after_clr", irq_status, 0);
    chk("soi_after_clr", soi, 0);
    issue_rd(0, 1'b1, 1'b1, 1'b0, mk(8'h40), mk(8'h50) + 128'd4); tick();
    chk("irq_after_5th", irq_status, 0);
    for (int k = 5; k < 7; k++) begin
      issue_rd(0, 1'b1, 1'b1, 1'b0, mk(8'h40), mk(8'h50) + 128'(k)); tick();
    end
    irq_clr = 4'b0001;
    issue_rd(0, 1'b1, 1'b1, 1'b0, mk(8'h40), mk(8'h50) + 128'd7); tick();
    chk("irq_set_beats_clr", irq_status, 4'b0001);
    issue_ld(0, mk(8'h40), mk(8'h50)); tick();
    chk("irq_kept_by_load", irq_status, 4'b0001);

    // Same-channel load + advance: load wins, response shows old values
    issue_ld(3, mk(8'h60), mk(8'h70)); tick();
    issue_ld(3, mk(8'h80), mk(8'h90));
    issue_rd(3, 1'b1, 1'b1, 1'b0, mk(8'h60), mk(8'h70)); tick();
    issue_rd(3, 1'b0, 1'b1, 1'b0, mk(8'h80), mk(8'h90)); tick();
    for (int j = 0; j < 3; j++) begin
      issue_rd(3, 1'b1, 1'b1, 1'b0, mk(8'h80), mk(8'h90) + 128'(j)); tick();
    end
    chk("irq_ch3_cnt_reset", irq_status, 4'b0001);
    issue_rd(3, 1'b1, 1'b1, 1'b0, mk(8'h80), mk(8'h90) + 128'd3); tick();
    chk("irq_ch3_overflow", irq_status, 4'b1001);

    // Different-channel load and read in one cycle
    issue_ld(1, mk(8'hC0), mk(8'hD0));
    issue_rd(2, 1'b1, 1'b1, 1'b0, mk(8'h00), mk(8'h10)); tick();
    issue_rd(1, 1'b0, 1'b1, 1'b0, mk(8'hC0), mk(8'hD0)); tick();
    issue_rd(2, 1'b0, 1'b1, 1'b0, mk(8'h00), mk(8'h10) + 128'd1); tick();

    // Reset asserted mid-stream with a load and read pending
    issue_rd(2, 1'b0, 1'b1, 1'b0, mk(8'h00), mk(8'h10) + 128'd1); tick();
    @(negedge clk);
    #1;
    issue_ld(0, mk(8'hA0), mk(8'hB0));
    issue_rd(2, 1'b1, 1'b0, 1'b0, '0, '0);
    rst = 1'b0;
    #1;
    chk("arst_out_vld", out_vld, 0);
    chk("arst_out_err", out_err, 0);
    chk("arst_key", key, 0);
    chk("arst_sync", sync, 0);
    chk("arst_ctx", ctx_vld, 0);
    chk("arst_irq", irq_status, 0);
    chk("arst_soi", soi, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_ctx", ctx_vld, 0);
    chk("post_rst_irq", irq_status, 0);
    issue_rd(2, 1'b0, 1'b1, 1'b1, '0, '0); tick();
    repeat (3) tick();
    chk("queue_drained", 128'(q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/key_sync_context_bank.md
KEY_SYNC_CONTEXT_BANK -- requirements
Module: key_sync_context_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning the number of independent key/sync contexts (1..16).
REQ-002 SHALL have parameter CNT_W, default 16, meaning the per-channel sync-advance counter width (1..32).
REQ-003 SHALL have parameter CH_W, default $clog2(NUM_CH) floored at 1, meaning the channel index width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 Port rst  input  1  asynchronous, active-low reset.
REQ-007 Port key_and_sync_in  dvr_if.slave  2*BLOCK_SIZE bytes  load stream; key in bytes [BLOCK_SIZE-1:0], sync in bytes [2*BLOCK_SIZE-1:BLOCK_SIZE].
REQ-008 Port load_en  input  1  load permission; drives key_and_sync_in.rdy directly.
REQ-009 Port load_ch  input  CH_W  target channel of the current load.
REQ-010 Port blk_req  input  1  read request for one block's key/sync.
REQ-011 Port blk_ch  input  CH_W  channel to read.
REQ-012 Port blk_advance  input  1  with blk_req, increment the channel's stored sync after the read.
REQ-013 Port irq_clr  input  NUM_CH  write-1-to-clear of the per-channel overlap flags.
REQ-014 Port key  output  aes_model_pack::byte_table  key of the read channel.
REQ-015 Port sync  output  aes_model_pack::byte_table  sync of the read channel.
REQ-016 Port out_vld  output  1  key/sync/out_err valid, one cycle.
REQ-017 Port out_err  output  1  read targeted an unloaded or out-of-range channel.
REQ-018 Port ctx_vld  output  NUM_CH  per-channel "context loaded" flags.
REQ-019 Port irq_status  output  NUM_CH  sticky per-channel sync-overlap flags.
REQ-020 Port sync_overlapse_irq  output  1  OR-reduction of irq_status.

Function
REQ-021 Load handshake: key_and_sync_in.rdy SHALL equal load_en combinationally; acceptance (act) SHALL be valid & rdy.
REQ-022 On act with load_ch < NUM_CH, the channel's key and sync SHALL be written, its counter SHALL be set to 0, and ctx_vld[load_ch] SHALL be set, all at the next edge.
REQ-023 An act with load_ch >= NUM_CH SHALL be consumed and discarded.
REQ-024 A read SHALL have one-cycle latency: blk_req at cycle N gives out_vld=1 at N+1, with key/sync equal to the stored values before any cycle-N update.
REQ-025 When the read channel has ctx_vld=0 or blk_ch >= NUM_CH, the response SHALL have out_err=1 and key=sync=0, and no advance.
REQ-026 out_vld, key, sync and out_err SHALL hold 0 in cycles without a response.
REQ-027 An advance (blk_req & blk_advance on a valid channel) SHALL set stored sync to sync+1, modulo 2^(8*BLOCK_SIZE), as one full-width unsigned addition.
REQ-028 An advance SHALL increment the channel counter modulo 2^CNT_W.
REQ-029 An advance when the counter equals 2^CNT_W-1 SHALL set irq_status[ch] and wrap the counter to 0.
REQ-030 irq_status bits SHALL be sticky until cleared by irq_clr; a same-cycle set SHALL override the clear.
REQ-031 A load SHALL NOT clear irq_status.
REQ-032 Same-channel load and advance in one cycle: the load SHALL win (new sync, counter 0, no irq); the read response SHALL return the pre-load values.
REQ-033 Different-channel load and read in one cycle SHALL both take effect independently.
REQ-034 Channels SHALL be fully independent; no operation on one channel SHALL alter another channel's state.

Reset
REQ-035 While rst=0, all keys, syncs and counters SHALL be 0, along with ctx_vld, irq_status, out_vld, out_err, key, sync and sync_overlapse_irq; reset SHALL apply asynchronously.
REQ-036 A reset during a load or read SHALL discard that operation; no response SHALL appear after deassertion.

Verification
REQ-037 Load ch2 (key=0x00..0F, sync=0x10..1F), then blk_req ch2 -> out_vld=1 one cycle later with exact key/sync, out_err=0.
REQ-038 Load sync=0xFF..FF into ch1, then advance -> next read of ch1 returns sync=0x00..00, irq_status=0.
REQ-039 With CNT_W=2: load ch0, then 4 advances -> irq_status[0]=1 after the 4th, sync_overlapse_irq=1; irq_clr[0] clears it; a 5th advance does not set it.
REQ-040 Same-cycle load ch3 plus read+advance ch3 -> response shows old values; later read shows the new sync, counter 0.
REQ-041 Read of unloaded ch1, or blk_ch=NUM_CH -> out_vld=1, out_err=1, key=sync=0, no state change.
REQ-042 Assert rst mid-stream with load_en=1 and valid=1 -> all outputs 0 immediately; ctx_vld=0 after release.
